// File: rtl/dac_btn_sequencer.sv
// dac_btn_sequencer: button-driven level control and SPI frame sequencing for the LTC2624 DAC
//
// Ports:
//   CLK50MHZ  in   system clock, 50 MHz
//   RST       in   asynchronous reset, active-high
//   BTN_WEST  in   raw button, rising edge decrements level by STEP (saturating at 0)
//   BTN_EAST  in   raw button, rising edge increments level by STEP (saturating at 4095)
//   SPI_MOSI  out  serial data to the DAC, MSB first, changes on SCK falling edge
//   SPI_SCK   out  serial clock, idles low, half-period CLK_DIV clocks
//   DAC_CS    out  DAC chip select, active-low
//   DAC_CLR   out  DAC clear, active-low; released on the first clock after reset
//   busy      out  high from LOAD through GAP of a frame
//   level     out  current committed 12-bit DAC code
//
// Optional feature: define DAC_MIDSCALE_ON_BOTH_EN so that simultaneous WEST and
// EAST events load mid-scale (12'h800) and queue a frame; otherwise they are ignored.
module dac_btn_sequencer #(
    parameter int          STEP       = 16,
    parameter int          CLK_DIV    = 2,
    parameter logic [3:0]  DAC_CMD    = 4'h3,
    parameter logic [3:0]  DAC_ADDR   = 4'hF,
    parameter logic [11:0] INIT_LEVEL = 12'h800
) (
    input  logic        CLK50MHZ,
    input  logic        RST,
    input  logic        BTN_WEST,
    input  logic        BTN_EAST,
    output logic        SPI_MOSI,
    output logic        SPI_SCK,
    output logic        DAC_CS,
    output logic        DAC_CLR,
    output logic        busy,
    output logic [11:0] level
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

    localparam int             CW       = $clog2(2 * CLK_DIV + 1);
    localparam logic [CW-1:0]  BIT_LAST = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0]  GAP_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]  SCK_HI   = CW'(CLK_DIV);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [4:0]    bit_idx, bit_n;
    logic [31:0]   sr, sr_n;
    logic          pending, load;
    // [0],[1] form the synchronizer, [2] holds the previous synced value for edge detection
    logic [2:0]    w_sync, e_sync;
    logic          ev_w, ev_e, accept;
    logic [12:0]   up_sum;
    logic [11:0]   level_up, level_dn, level_n;

    assign ev_w     = w_sync[1] & ~w_sync[2];
    assign ev_e     = e_sync[1] & ~e_sync[2];
    assign up_sum   = {1'b0, level} + 13'(STEP);
    assign level_up = (up_sum > 13'd4095) ? 12'hFFF : up_sum[11:0];
    assign level_dn = ({1'b0, level} < 13'(STEP)) ? 12'h000 : level - 12'(STEP);

    always_comb begin
`ifdef DAC_MIDSCALE_ON_BOTH_EN
        accept  = ev_w | ev_e;
        level_n = (ev_w & ev_e) ? 12'h800 : ev_e ? level_up : ev_w ? level_dn : level;
`else
        accept  = ev_w ^ ev_e;
        level_n = !accept ? level : ev_e ? level_up : level_dn;
`endif
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        sr_n    = sr;
        load    = 1'b0;
        case (state)
            IDLE: begin
                // The frame is captured on entry to LOAD so its data is stable for the whole frame
                if (pending && DAC_CLR) begin
                    state_n = LOAD;
                    load    = 1'b1;
                    sr_n    = {8'h00, DAC_CMD, DAC_ADDR, level, 4'h0};
                    cnt_n   = '0;
                    bit_n   = '0;
                end
            end
            LOAD: state_n = SHIFT;
            SHIFT: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (bit_idx == 5'd31) begin
                        state_n = GAP;
                    end else begin
                        bit_n = bit_idx + 5'd1;
                        sr_n  = {sr[30:0], 1'b0};
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Bus outputs are registered from next-state values so the pins are glitch-free
    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            sr       <= '0;
            pending  <= 1'b1;
            level    <= INIT_LEVEL;
            DAC_CLR  <= 1'b0;
            w_sync   <= '0;
            e_sync   <= '0;
            SPI_MOSI <= 1'b0;
            SPI_SCK  <= 1'b0;
            DAC_CS   <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_n;
            sr       <= sr_n;
            // An event in the capture cycle re-arms pending so its new level gets its own frame
            pending  <= accept | (pending & ~load);
            level    <= level_n;
            DAC_CLR  <= 1'b1;
            w_sync   <= {w_sync[1:0], BTN_WEST};
            e_sync   <= {e_sync[1:0], BTN_EAST};
            SPI_MOSI <= (state_n == LOAD || state_n == SHIFT) & sr_n[31];
            SPI_SCK  <= (state_n == SHIFT) && (cnt_n >= SCK_HI);
            DAC_CS   <= !(state_n == LOAD || state_n == SHIFT);
            busy     <= state_n != IDLE;
        end
    end
endmodule

// File: tb/tb_dac_btn_sequencer.sv
// tb_dac_btn_sequencer: self-checking bench for dac_btn_sequencer
module tb_dac_btn_sequencer;
    logic        CLK50MHZ = 1'b0;
    logic        RST = 1'b0;
    logic        BTN_WEST = 1'b0;
    logic        BTN_EAST = 1'b0;
    logic        SPI_MOSI, SPI_SCK, DAC_CS, DAC_CLR, busy;
    logic [11:0] level;

    dac_btn_sequencer dut (
        .CLK50MHZ(CLK50MHZ), .RST(RST), .BTN_WEST(BTN_WEST), .BTN_EAST(BTN_EAST),
        .SPI_MOSI(SPI_MOSI), .SPI_SCK(SPI_SCK), .DAC_CS(DAC_CS), .DAC_CLR(DAC_CLR),
        .busy(busy), .level(level)
    );

    always #10 CLK50MHZ = ~CLK50MHZ;

    typedef struct {
        logic        w;
        logic        e;
        int          hold;
        logic [11:0] lvl;
        logic        frame;
    } vec_t;

    int          vectors = 0;
    int          errors = 0;
    int          frames = 0;
    int          nbits = 0;
    int          cs_cycles = 0;
    logic [31:0] sb[$];
    bit          skip = 1'b0;
    logic [31:0] cap = '0;
    logic [31:0] last_word = '0;
    logic        prev_sck = 1'b0;
    logic        prev_cs = 1'b1;

    function automatic logic [31:0] word_of(input logic [11:0] l);
        return {8'h00, 4'h3, 4'hF, l, 4'h0};
    endfunction

    function automatic logic [11:0] sat(input int v);
        return v > 4095 ? 12'hFFF : v < 0 ? 12'h000 : 12'(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame monitor: decodes the SPI pins and compares each completed frame with the scoreboard
    always @(negedge CLK50MHZ) begin
        if (RST) begin
            nbits = 0;
            cs_cycles = 0;
            cap = '0;
            prev_cs = 1'b1;
            prev_sck = 1'b0;
        end else begin
            if (!DAC_CS) begin
                cs_cycles++;
                if (SPI_SCK && !prev_sck) begin
                    cap = {cap[30:0], SPI_MOSI};
                    nbits++;
                end
            end
            if (!prev_cs && DAC_CS) begin
                frames++;
                last_word = cap;
                check("frame_bits", nbits, 32);
                check("cs_low_cycles", cs_cycles, 129);
                if (!skip) begin
                    if (sb.size() == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL unexpected_frame: got 0x%0h expected no frame", cap);
                    end else begin
                        check("frame_word", cap, sb.pop_front());
                    end
                end
                nbits = 0;
                cs_cycles = 0;
                cap = '0;
            end
            prev_cs = DAC_CS;
            prev_sck = SPI_SCK;
        end
    end

    task automatic press(input logic w, input logic e, input int hold);
        @(posedge CLK50MHZ); #1;
        BTN_WEST = w;
        BTN_EAST = e;
        repeat (hold) @(posedge CLK50MHZ);
        #1;
        BTN_WEST = 1'b0;
        BTN_EAST = 1'b0;
        repeat (4) @(posedge CLK50MHZ);
    endtask

    task automatic ramp(input logic w, input logic e, input int n);
        for (int i = 0; i < n; i++) press(w, e, 2);
    endtask

    task automatic wait_idle(input string name);
        int quiet = 0;
        int n = 0;
        while (quiet < 8 && n < 2000) begin
            @(negedge CLK50MHZ);
            quiet = busy ? 0 : quiet + 1;
            n++;
        end
        if (quiet < 8) begin
            vectors++;
            errors++;
            $display("FAIL %s_timeout: got busy after %0d cycles expected idle", name, n);
        end
    endtask

    task automatic single(input string name, input logic w, input logic e, input logic [11:0] lvl);
        int f0 = frames;
        sb.push_back(word_of(lvl));
        press(w, e, 2);
        wait_idle(name);
        check({name, "_level"}, level, lvl);
        check({name, "_frames"}, frames - f0, 1);
    endtask

    vec_t        tbl[5];
    logic [11:0] exp_lvl;
    int          f0, n;

    initial begin
        tbl[0] = '{w: 1'b1, e: 1'b0, hold: 50, lvl: 12'h7F0, frame: 1'b1};
        tbl[1] = '{w: 1'b0, e: 1'b1, hold: 2,  lvl: 12'h800, frame: 1'b1};
        tbl[2] = '{w: 1'b0, e: 1'b1, hold: 2,  lvl: 12'h810, frame: 1'b1};
`ifdef DAC_MIDSCALE_ON_BOTH_EN
        tbl[3] = '{w: 1'b1, e: 1'b1, hold: 2,  lvl: 12'h800, frame: 1'b1};
        tbl[4] = '{w: 1'b1, e: 1'b0, hold: 2,  lvl: 12'h7F0, frame: 1'b1};
`else
        tbl[3] = '{w: 1'b1, e: 1'b1, hold: 2,  lvl: 12'h810, frame: 1'b0};
        tbl[4] = '{w: 1'b1, e: 1'b0, hold: 2,  lvl: 12'h800, frame: 1'b1};
`endif

        // Reset state and power-up frame
        #1 RST = 1'b1;
        repeat (3) @(posedge CLK50MHZ);
        @(negedge CLK50MHZ);
        check("rst_cs", DAC_CS, 1);
        check("rst_sck", SPI_SCK, 0);
        check("rst_mosi", SPI_MOSI, 0);
        check("rst_clr", DAC_CLR, 0);
        check("rst_busy", busy, 0);
        check("rst_level", level, 12'h800);
        sb.push_back(word_of(12'h800));
        @(posedge CLK50MHZ); #1;
        RST = 1'b0;
        @(negedge CLK50MHZ);
        check("clr_before_edge", DAC_CLR, 0);
        @(negedge CLK50MHZ);
        check("clr_after_edge", DAC_CLR, 1);
        wait_idle("powerup");
        check("powerup_frames", frames, 1);
        check("powerup_level", level, 12'h800);

        // Table of single presses
        for (int i = 0; i < 5; i++) begin
            wait_idle("tbl_pre");
            f0 = frames;
            if (tbl[i].frame) sb.push_back(word_of(tbl[i].lvl));
            press(tbl[i].w, tbl[i].e, tbl[i].hold);
            wait_idle("tbl");
            check($sformatf("tbl%0d_level", i), level, tbl[i].lvl);
            check($sformatf("tbl%0d_frames", i), frames - f0, tbl[i].frame ? 1 : 0);
        end
        exp_lvl = tbl[4].lvl;

        // Event latency: level changes on the third clock after the raw edge
        f0 = frames;
        exp_lvl = sat(int'(exp_lvl) + 16);
        sb.push_back(word_of(exp_lvl));
        @(posedge CLK50MHZ); #1;
        BTN_EAST = 1'b1;
        repeat (2) @(posedge CLK50MHZ);
        @(negedge CLK50MHZ);
        check("latency_before", level, sat(int'(exp_lvl) - 16));
        @(negedge CLK50MHZ);
        check("latency_after", level, exp_lvl);
        BTN_EAST = 1'b0;
        wait_idle("latency");
        check("latency_frames", frames - f0, 1);

        // Three presses during one frame coalesce into one follow-up frame
        f0 = frames;
        exp_lvl = sat(int'(exp_lvl) - 16);
        sb.push_back(word_of(exp_lvl));
        press(1'b1, 1'b0, 2);
        check("coalesce_busy", busy, 1);
        ramp(1'b0, 1'b1, 3);
        check("coalesce_still_busy", busy, 1);
        exp_lvl = sat(int'(exp_lvl) + 48);
        sb.push_back(word_of(exp_lvl));
        wait_idle("coalesce");
        check("coalesce_level", level, exp_lvl);
        check("coalesce_frames", frames - f0, 2);

        // Saturation at full scale
        n = (4080 - int'(exp_lvl)) / 16;
        skip = 1'b1;
        ramp(1'b0, 1'b1, n);
        wait_idle("ramp_up");
        skip = 1'b0;
        check("ramp_up_level", level, 12'hFF0);
        check("ramp_up_last_word", last_word, word_of(12'hFF0));
        single("sat_hi1", 1'b0, 1'b1, 12'hFFF);
        single("sat_hi2", 1'b0, 1'b1, 12'hFFF);

        // Saturation at zero
        skip = 1'b1;
        ramp(1'b1, 1'b0, 255);
        wait_idle("ramp_dn");
        skip = 1'b0;
        check("ramp_dn_level", level, 12'h00F);
        check("ramp_dn_last_word", last_word, word_of(12'h00F));
        single("sat_lo1", 1'b1, 1'b0, 12'h000);
        single("sat_lo2", 1'b1, 1'b0, 12'h000);

        // Reset at the tenth SCK rising edge aborts the frame and re-issues power-up
        press(1'b0, 1'b1, 2);
        n = 0;
        while (nbits < 10 && n < 500) begin
            @(negedge CLK50MHZ);
            n++;
        end
        check("abort_reached_edge10", nbits, 10);
        @(posedge CLK50MHZ); #1;
        RST = 1'b1;
        #1;
        check("abort_cs", DAC_CS, 1);
        check("abort_sck", SPI_SCK, 0);
        check("abort_clr", DAC_CLR, 0);
        check("abort_busy", busy, 0);
        check("abort_level", level, 12'h800);
        f0 = frames;
        sb.push_back(word_of(12'h800));
        repeat (3) @(posedge CLK50MHZ);
        #1 RST = 1'b0;
        wait_idle("repowerup");
        check("repowerup_frames", frames - f0, 1);
        check("repowerup_level", level, 12'h800);
        check("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
